// File: rtl/cv_irq_ctrl_if.sv
// CPU-side register/interrupt bus of the CV interrupt controller.
// The controller uses the slave modport; the CPU (or a bench) drives the master side.
interface cv_irq_ctrl_if;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       iack;
    logic       irq;
    logic [7:0] vector;

    modport master (
        output wr,
        output addr,
        output wdata,
        output iack,
        input  rdata,
        input  irq,
        input  vector
    );

    modport slave (
        input  wr,
        input  addr,
        input  wdata,
        input  iack,
        output rdata,
        output irq,
        output vector
    );
endinterface

// File: rtl/cv_irq_ctrl.sv
// cv_irq_ctrl: multi-source interrupt controller for the CV subsystem.
// Rising edges on src latch into PENDING, get masked by ENABLE, and a small
// IDLE/REQ/SERVICE sequencer raises irq, hands out a priority-encoded vector
// on iack and stays blocked until the CPU writes end-of-interrupt (addr 3).
module cv_irq_ctrl #(
    parameter int N_SRC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    cv_irq_ctrl_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_BASE    = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // Offset used for the spurious vector, one slot past the last real source.
    localparam logic [7:0] SPUR_OFS = 8'(2 * N_SRC);

    state_t           state;
    logic [N_SRC-1:0] src_d;
    logic [N_SRC-1:0] enable;
    logic [N_SRC-1:0] pending;
    logic [7:0]       base;
    logic [7:0]       vector_q;
    logic             irq_q;
    logic [2:0]       idx_q;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] active;
    logic [N_SRC-1:0] low_bit;
    logic [N_SRC-1:0] w1c_clr;
    logic [N_SRC-1:0] ack_clr;
    logic             req;
    logic             accept;
    logic             eoi;
    logic [2:0]       idx;
    logic [7:0]       enable_rd;
    logic [7:0]       pending_rd;
    logic [7:0]       status_rd;
    logic [7:0]       rdata;

    // Event and request decode, all from registered state.
    assign rise    = src & ~src_d;
    assign active  = pending & enable;
    assign req     = |active;
    // Isolate the lowest set bit: that is the highest-priority active source.
    assign low_bit = active & (~active + N_SRC'(1));
    assign accept  = (state == REQ) && bus.iack && req;
    assign eoi     = bus.wr && (bus.addr == ADDR_STATUS);
    assign w1c_clr = (bus.wr && (bus.addr == ADDR_PENDING)) ? bus.wdata[N_SRC-1:0] : '0;
    assign ack_clr = accept ? low_bit : '0;

    // Priority encoder: index of the lowest active source (0 when none).
    always_comb begin
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                idx = 3'(i);
            end
        end
    end

    // Previous-cycle source levels; all ones so sources high at reset release are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_d <= '1;
        end else begin
            src_d <= src;
        end
    end

    // ENABLE and BASE registers written by the CPU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable <= '0;
            base   <= '0;
        end else if (bus.wr) begin
            if (bus.addr == ADDR_ENABLE) begin
                enable <= bus.wdata[N_SRC-1:0];
            end
            if (bus.addr == ADDR_BASE) begin
                base <= bus.wdata;
            end
        end
    end

    // PENDING latch: a new edge wins over a W1C clear or an acknowledge clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~w1c_clr & ~ack_clr) | rise;
        end
    end

    // Request/acknowledge/service sequencer with registered irq, vector and idx.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            irq_q    <= 1'b0;
            vector_q <= 8'h00;
            idx_q    <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= REQ;
                        irq_q <= 1'b1;
                    end else begin
                        irq_q <= 1'b0;
                    end
                end
                REQ: begin
                    if (bus.iack) begin
                        irq_q <= 1'b0;
                        if (req) begin
                            vector_q <= base + {4'b0000, idx, 1'b0};
                            idx_q    <= idx;
                            state    <= SERVICE;
                        end else begin
                            // Nothing left to service: hand out the spurious vector.
                            vector_q <= base + SPUR_OFS;
                            state    <= IDLE;
                        end
                    end else if (!req) begin
                        // Source masked or cleared before the CPU acknowledged.
                        irq_q <= 1'b0;
                        state <= IDLE;
                    end else begin
                        irq_q <= 1'b1;
                    end
                end
                SERVICE: begin
                    irq_q <= 1'b0;
                    if (eoi) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    irq_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read mux; unimplemented source bits read as zero.
    always_comb begin
        enable_rd              = '0;
        enable_rd[N_SRC-1:0]   = enable;
        pending_rd             = '0;
        pending_rd[N_SRC-1:0]  = pending;
        status_rd              = {(state == SERVICE), 2'b00, state, idx_q};
        rdata                  = 8'h00;
        case (bus.addr)
            ADDR_ENABLE:  rdata = enable_rd;
            ADDR_PENDING: rdata = pending_rd;
            ADDR_BASE:    rdata = base;
            ADDR_STATUS:  rdata = status_rd;
            default:      rdata = 8'h00;
        endcase
    end

    assign bus.rdata  = rdata;
    assign bus.irq    = irq_q;
    assign bus.vector = vector_q;

endmodule

// File: tb/tb_cv_irq_ctrl.sv
// Bench for cv_irq_ctrl: directed vector table, reset corner sequences and a
// randomized run, all checked against a behavioural model of the controller.
module tb_cv_irq_ctrl;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] src;

    cv_irq_ctrl_if bus ();

    cv_irq_ctrl #(.N_SRC(N)) dut (
        .clk   (clk),
        .reset (reset),
        .src   (src),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: per-source flags and a service mode number.
    bit         m_pend [8];
    bit         m_en   [8];
    bit         m_prev [8];
    logic [7:0] m_base;
    logic [7:0] m_vec;
    int         m_mode;   // 0 waiting, 1 requesting, 2 in service
    int         m_idx;
    bit         m_irq;

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [3:0] src;
        logic       iack;
        logic       irq;
        logic [7:0] vec;
        logic [7:0] rd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_pend[i] = 1'b0;
            m_en[i]   = 1'b0;
            m_prev[i] = 1'b1;
        end
        m_base = 8'h00;
        m_vec  = 8'h00;
        m_mode = 0;
        m_idx  = 0;
        m_irq  = 1'b0;
    endtask

    function automatic logic [7:0] m_rd(input logic [1:0] a);
        logic [7:0] r;
        r = 8'h00;
        case (a)
            2'd0: for (int i = 0; i < N; i++) r[i] = m_en[i];
            2'd1: for (int i = 0; i < N; i++) r[i] = m_pend[i];
            2'd2: r = m_base;
            default: r = {(m_mode == 2), 2'b00, 2'(m_mode), 3'(m_idx)};
        endcase
        return r;
    endfunction

    task automatic model_step(input logic w, input logic [1:0] a, input logic [7:0] d,
                              input logic [N-1:0] s, input logic ack);
        int low;
        int nmode;
        bit req;
        bit take;
        low = -1;
        for (int i = 0; i < N; i++)
            if (m_pend[i] && m_en[i] && low < 0) low = i;
        req   = (low >= 0);
        take  = (m_mode == 1) && ack && req;
        nmode = m_mode;
        if (m_mode == 0) begin
            if (req) nmode = 1;
        end else if (m_mode == 1) begin
            if (ack) begin
                if (req) begin
                    m_vec = 8'((int'(m_base) + 2 * low) % 256);
                    m_idx = low;
                    nmode = 2;
                end else begin
                    m_vec = 8'((int'(m_base) + 2 * N) % 256);
                    nmode = 0;
                end
            end else if (!req) begin
                nmode = 0;
            end
        end else begin
            if (w && a == 2'd3) nmode = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (s[i] && !m_prev[i]) m_pend[i] = 1'b1;
            else if ((w && a == 2'd1 && d[i]) || (take && i == low)) m_pend[i] = 1'b0;
        end
        if (w && a == 2'd0) for (int i = 0; i < N; i++) m_en[i] = d[i];
        if (w && a == 2'd2) m_base = d;
        for (int i = 0; i < N; i++) m_prev[i] = s[i];
        m_mode = nmode;
        m_irq  = (nmode == 1);
    endtask

    // One clock with the given inputs; outputs compared against the model after the edge.
    task automatic cycle(input logic w, input logic [1:0] a, input logic [7:0] d,
                         input logic [N-1:0] s, input logic ack);
        bus.wr    = w;
        bus.addr  = a;
        bus.wdata = d;
        bus.iack  = ack;
        src       = s;
        @(posedge clk);
        model_step(w, a, d, s, ack);
        #1;
        chk("model_irq", {7'b0, bus.irq}, {7'b0, m_irq});
        chk("model_vector", bus.vector, m_vec);
        chk($sformatf("model_rdata_a%0d", a), bus.rdata, m_rd(a));
    endtask

    task automatic add(input logic w, input logic [1:0] a, input logic [7:0] d, input logic [3:0] s,
                       input logic ack, input logic eirq, input logic [7:0] evec, input logic [7:0] erd);
        vec_t v;
        v.wr = w; v.addr = a; v.wdata = d; v.src = s; v.iack = ack;
        v.irq = eirq; v.vec = evec; v.rd = erd;
        tbl.push_back(v);
    endtask

    initial begin
        reset     = 1'b1;
        src       = '0;
        bus.wr    = 1'b0;
        bus.addr  = 2'd0;
        bus.wdata = 8'h00;
        bus.iack  = 1'b0;
        model_reset();

        // Single source: enable, edge, acknowledge, EOI.
        add(1'b1,2'd0,8'h01,4'h0,1'b0, 1'b0,8'h00,8'h01);
        add(1'b1,2'd2,8'h40,4'h0,1'b0, 1'b0,8'h00,8'h40);
        add(1'b0,2'd1,8'h00,4'h1,1'b0, 1'b0,8'h00,8'h01);
        add(1'b0,2'd3,8'h00,4'h1,1'b0, 1'b1,8'h00,8'h08);
        add(1'b0,2'd3,8'h00,4'h0,1'b1, 1'b0,8'h40,8'h90);
        add(1'b0,2'd1,8'h00,4'h0,1'b0, 1'b0,8'h40,8'h00);
        add(1'b1,2'd3,8'h00,4'h0,1'b0, 1'b0,8'h40,8'h00);
        // Two simultaneous sources, priority order and vector wrap region.
        add(1'b1,2'd0,8'h0F,4'h0,1'b0, 1'b0,8'h40,8'h0F);
        add(1'b1,2'd2,8'hF8,4'h0,1'b0, 1'b0,8'h40,8'hF8);
        add(1'b0,2'd1,8'h00,4'hA,1'b0, 1'b0,8'h40,8'h0A);
        add(1'b0,2'd3,8'h00,4'hA,1'b0, 1'b1,8'h40,8'h08);
        add(1'b0,2'd1,8'h00,4'hA,1'b1, 1'b0,8'hFA,8'h08);
        add(1'b0,2'd3,8'h00,4'hA,1'b0, 1'b0,8'hFA,8'h91);
        add(1'b1,2'd3,8'h00,4'hA,1'b0, 1'b0,8'hFA,8'h01);
        add(1'b0,2'd3,8'h00,4'hA,1'b0, 1'b1,8'hFA,8'h09);
        add(1'b0,2'd3,8'h00,4'hA,1'b1, 1'b0,8'hFE,8'h93);
        add(1'b1,2'd3,8'h00,4'h0,1'b0, 1'b0,8'hFE,8'h03);
        // Masked pending source, enable later, then W1C while requesting.
        add(1'b1,2'd0,8'h00,4'h0,1'b0, 1'b0,8'hFE,8'h00);
        add(1'b0,2'd1,8'h00,4'h4,1'b0, 1'b0,8'hFE,8'h04);
        add(1'b0,2'd1,8'h00,4'h4,1'b0, 1'b0,8'hFE,8'h04);
        add(1'b1,2'd0,8'h04,4'h4,1'b0, 1'b0,8'hFE,8'h04);
        add(1'b0,2'd3,8'h00,4'h4,1'b0, 1'b1,8'hFE,8'h0B);
        add(1'b1,2'd1,8'h04,4'h4,1'b0, 1'b1,8'hFE,8'h00);
        add(1'b0,2'd3,8'h00,4'h4,1'b0, 1'b0,8'hFE,8'h03);
        // iack together with W1C of the only pending bit; events during service.
        add(1'b0,2'd1,8'h00,4'h0,1'b0, 1'b0,8'hFE,8'h00);
        add(1'b0,2'd1,8'h00,4'h4,1'b0, 1'b0,8'hFE,8'h04);
        add(1'b0,2'd3,8'h00,4'h4,1'b0, 1'b1,8'hFE,8'h0B);
        add(1'b1,2'd1,8'h04,4'h4,1'b1, 1'b0,8'hFC,8'h00);
        add(1'b0,2'd3,8'h00,4'h4,1'b0, 1'b0,8'hFC,8'h92);
        add(1'b0,2'd3,8'h00,4'h0,1'b1, 1'b0,8'hFC,8'h92);
        add(1'b0,2'd1,8'h00,4'h4,1'b0, 1'b0,8'hFC,8'h04);
        add(1'b0,2'd1,8'h00,4'h4,1'b0, 1'b0,8'hFC,8'h04);
        add(1'b1,2'd3,8'h00,4'h4,1'b0, 1'b0,8'hFC,8'h02);
        add(1'b0,2'd3,8'h00,4'h4,1'b0, 1'b1,8'hFC,8'h0A);
        // Spurious acknowledge after the request was withdrawn: F8 + 8 wraps to 00.
        add(1'b1,2'd1,8'h04,4'h4,1'b0, 1'b1,8'hFC,8'h00);
        add(1'b0,2'd3,8'h00,4'h4,1'b1, 1'b0,8'h00,8'h02);

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_irq", {7'b0, bus.irq}, 8'h00);
        chk("reset_vector", bus.vector, 8'h00);
        for (int a = 0; a < 4; a++) begin
            bus.addr = 2'(a);
            #1;
            chk($sformatf("reset_rdata_a%0d", a), bus.rdata, 8'h00);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].src, tbl[i].iack);
            chk($sformatf("tbl%0d_irq", i), {7'b0, bus.irq}, {7'b0, tbl[i].irq});
            chk($sformatf("tbl%0d_vector", i), bus.vector, tbl[i].vec);
            chk($sformatf("tbl%0d_rdata", i), bus.rdata, tbl[i].rd);
        end

        // Source held high across reset release produces no event.
        @(negedge clk);
        src   = 4'h1;
        reset = 1'b1;
        model_reset();
        #2;
        reset = 1'b0;
        cycle(1'b0, 2'd1, 8'h00, 4'h1, 1'b0);
        chk("held_src_no_pending", bus.rdata, 8'h00);
        cycle(1'b0, 2'd1, 8'h00, 4'h0, 1'b0);
        cycle(1'b0, 2'd1, 8'h00, 4'h1, 1'b0);
        chk("reedge_pending", bus.rdata, 8'h01);

        // Asynchronous reset while in service.
        cycle(1'b1, 2'd2, 8'h20, 4'h1, 1'b0);
        cycle(1'b1, 2'd0, 8'h01, 4'h1, 1'b0);
        cycle(1'b0, 2'd3, 8'h00, 4'h1, 1'b0);
        chk("svc_irq_up", {7'b0, bus.irq}, 8'h01);
        cycle(1'b0, 2'd3, 8'h00, 4'h1, 1'b1);
        chk("svc_vector", bus.vector, 8'h20);
        chk("svc_status", bus.rdata, 8'h90);
        bus.iack = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_irq", {7'b0, bus.irq}, 8'h00);
        chk("async_vector", bus.vector, 8'h00);
        chk("async_status", bus.rdata, 8'h00);
        @(negedge clk);
        bus.addr = 2'd0;
        #1;
        chk("async_enable", bus.rdata, 8'h00);
        reset = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic       w;
            logic       k;
            logic [1:0] a;
            logic [7:0] d;
            logic [N-1:0] s;
            w = ($urandom_range(0, 99) < 20);
            k = ($urandom_range(0, 99) < 15);
            a = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            s = N'($urandom);
            cycle(w, a, d, s, k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
